cc_line_fill_assembler: RTL and testbench

CC_LINE_FILL_ASSEMBLER -- requirements
Module: cc_line_fill_assembler

---
 rtl/cc_line_fill_assembler.sv | 139 +++++++++++++
 tb/tb_cc_line_fill_assembler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_line_fill_assembler.sv
// Assembles a 512-bit cache line from a wrapped 64-bit AXI R burst (critical word first)
// and writes it to the tag/data SRAM, popping the miss-address FIFO once per fill.
module cc_line_fill_assembler #(
    parameter int unsigned BEATS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [63:0]  mem_rdata_i,
    input  logic [1:0]   mem_rresp_i,
    input  logic         mem_rlast_i,
    input  logic         mem_rvalid_i,
    output logic         mem_rready_o,
    input  logic         miss_addr_fifo_empty_i,
    input  logic [31:0]  miss_addr_fifo_rdata_i,
    output logic         miss_addr_fifo_rden_o,
    output logic         wren_o,
    output logic [8:0]   waddr_o,
    output logic [17:0]  wdata_tag_o,
    output logic [511:0] wdata_data_o,
    output logic         fill_busy_o,
    output logic         fill_err_o
);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

    localparam logic [2:0] LastBeat = 3'(BEATS - 1);

    state_e         state_q, state_d;
    logic [2:0]     beat_cnt_q, beat_cnt_d;
    logic [2:0]     start_q, start_d;
    logic [16:0]    tag_q, tag_d;
    logic [8:0]     index_q, index_d;
    logic           err_q, err_d;
    logic           rready_q, rready_d;
    logic           wren_q, wren_d;
    logic           rden_q, rden_d;
    logic           busy_q, busy_d;
    logic           fill_err_q, fill_err_d;
    logic [511:0]   line_q, line_d;

    logic           beat_hs;
    logic           last_expected;
    logic [2:0]     slot;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        start_d    = start_q;
        tag_d      = tag_q;
        index_d    = index_q;
        err_d      = err_q;
        line_d     = line_q;

        // rready_q is high exactly while in COLLECT
        beat_hs       = mem_rvalid_i & rready_q;
        last_expected = (beat_cnt_q == LastBeat);
        slot          = start_q + beat_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (!miss_addr_fifo_empty_i) begin
                    tag_d      = miss_addr_fifo_rdata_i[31:15];
                    index_d    = miss_addr_fifo_rdata_i[14:6];
                    start_d    = miss_addr_fifo_rdata_i[5:3];
                    beat_cnt_d = 3'd0;
                    err_d      = 1'b0;
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                if (beat_hs) begin
                    line_d[{slot, 6'd0} +: 64] = mem_rdata_i;
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if ((mem_rresp_i != 2'b00) || (mem_rlast_i != last_expected)) begin
                        err_d = 1'b1;
                    end
                    if (mem_rlast_i || last_expected) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rready_d   = (state_d == StCollect);
        wren_d     = (state_d == StWrite);
        rden_d     = (state_d == StWrite);
        busy_d     = (state_d != StIdle);
        fill_err_d = (state_d == StWrite) & err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= 3'd0;
            start_q    <= 3'd0;
            tag_q      <= 17'd0;
            index_q    <= 9'd0;
            err_q      <= 1'b0;
            rready_q   <= 1'b0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            busy_q     <= 1'b0;
            fill_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            start_q    <= start_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            err_q      <= err_d;
            rready_q   <= rready_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            busy_q     <= busy_d;
            fill_err_q <= fill_err_d;
        end
    end

    // Line buffer is fully overwritten by a good fill, so it carries no reset
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign mem_rready_o          = rready_q;
    assign miss_addr_fifo_rden_o = rden_q;
    assign wren_o                = wren_q;
    assign waddr_o               = index_q;
    assign wdata_tag_o           = {~err_q, tag_q};
    assign wdata_data_o          = line_q;
    assign fill_busy_o           = busy_q;
    assign fill_err_o            = fill_err_q;

endmodule

// File: tb/tb_cc_line_fill_assembler.sv
// Directed bench for cc_line_fill_assembler: FIFO model, burst driver and a write scoreboard.
module tb_cc_line_fill_assembler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  mem_rdata;
    logic [1:0]   mem_rresp;
    logic         mem_rlast;
    logic         mem_rvalid;
    logic         mem_rready_o;
    logic         fifo_empty;
    logic [31:0]  fifo_head;
    logic         fifo_rden_o;
    logic         wren_o;
    logic [8:0]   waddr_o;
    logic [17:0]  wdata_tag_o;
    logic [511:0] wdata_data_o;
    logic         fill_busy_o;
    logic         fill_err_o;

    always #5 clk = ~clk;

    cc_line_fill_assembler #(.BEATS(8)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .mem_rdata_i            (mem_rdata),
        .mem_rresp_i            (mem_rresp),
        .mem_rlast_i            (mem_rlast),
        .mem_rvalid_i           (mem_rvalid),
        .mem_rready_o           (mem_rready_o),
        .miss_addr_fifo_empty_i (fifo_empty),
        .miss_addr_fifo_rdata_i (fifo_head),
        .miss_addr_fifo_rden_o  (fifo_rden_o),
        .wren_o                 (wren_o),
        .waddr_o                (waddr_o),
        .wdata_tag_o            (wdata_tag_o),
        .wdata_data_o           (wdata_data_o),
        .fill_busy_o            (fill_busy_o),
        .fill_err_o             (fill_err_o)
    );

    typedef struct {
        logic [8:0]   idx;
        logic [17:0]  tag;
        logic [511:0] line;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    logic [31:0]  fifo_mem[8];
    int           wp = 0;
    int           rp = 0;
    int           cyc = 0;
    int           n_assert = 0;
    int           n_fail = 0;
    int           pushes = 0;
    int           last_hs_cyc = 0;
    int           first_hs_cyc = 0;
    int           last_wren_cyc = 0;
    bit           mon_en = 1'b0;
    logic [511:0] model_line = '0;

    assign fifo_empty = (wp == rp);
    assign fifo_head  = fifo_mem[rp % 8];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && fifo_rden_o) rp <= rp + 1;
    end

    task automatic check(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            check("rden_eq_wren", {511'd0, fifo_rden_o}, {511'd0, wren_o});
            if (!fill_busy_o) check("rready_idle", {511'd0, mem_rready_o}, '0);
            if (!wren_o) begin
                check("err_outside_write", {511'd0, fill_err_o}, '0);
            end else begin
                check("rready_write", {511'd0, mem_rready_o}, '0);
                check("latency", 512'(cyc), 512'(last_hs_cyc + 1));
                last_wren_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_write", 512'd1, 512'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("waddr", {503'd0, waddr_o}, {503'd0, e.idx});
                    check("wdata_tag", {494'd0, wdata_tag_o}, {494'd0, e.tag});
                    check("wdata_data", wdata_data_o, e.line);
                    check("fill_err", {511'd0, fill_err_o}, {511'd0, e.err});
                end
            end
        end
    end

    task automatic push_fifo(input logic [31:0] a);
        fifo_mem[wp % 8] = a;
        wp++;
    endtask

    // Drives one burst for address a; rlast on final beat only when send_last is set.
    task automatic send_burst(input logic [31:0] a, input logic [63:0] base, input int nbeats,
                              input int err_beat, input bit stall, input bit hold,
                              input bit send_last);
        logic [2:0] start;
        logic [2:0] slot;
        logic       err;
        exp_t       e;
        start = a[5:3];
        err   = send_last && (nbeats != 8);
        for (int k = 0; k < nbeats; k++) begin
            int t;
            if (stall && k > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    mem_rvalid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            mem_rvalid = 1'b1;
            mem_rdata  = base + 64'(k);
            mem_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            mem_rlast  = send_last && (k == nbeats - 1);
            t = 0;
            @(negedge clk);
            while (!mem_rready_o && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                check("handshake_timeout", 512'd1, 512'd0);
                mem_rvalid = 1'b0;
                return;
            end
            slot = start + 3'(k);
            model_line[{slot, 6'd0} +: 64] = base + 64'(k);
            if (k == err_beat) err = 1'b1;
            if (k == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            @(posedge clk);
            #1;
        end
        if (!hold) begin
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
        end
        if (send_last) begin
            e.idx  = a[14:6];
            e.tag  = {~err, a[31:15]};
            e.line = model_line;
            e.err  = err;
            sb.push_back(e);
            pushes++;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("write_timeout", 512'(sb.size()), 512'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b1;
        mem_rdata  = '0;
        mem_rresp  = 2'b00;
        mem_rlast  = 1'b0;
        mem_rvalid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_rready", {511'd0, mem_rready_o}, '0);
        check("rst_wren", {511'd0, wren_o}, '0);
        check("rst_rden", {511'd0, fifo_rden_o}, '0);
        check("rst_busy", {511'd0, fill_busy_o}, '0);
        check("rst_err", {511'd0, fill_err_o}, '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Aligned fill, offset 0
        push_fifo(32'h0001_2340);
        send_burst(32'h0001_2340, 64'hD000_0000_0000_0000, 8, -1, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // Wrapped fill starting at word 5
        push_fifo(32'h1234_56E8);
        send_burst(32'h1234_56E8, 64'hA5A5_0000_0000_0010, 8, -1, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // SLVERR on beat 3
        push_fifo(32'h0000_0040);
        send_burst(32'h0000_0040, 64'h3333_0000_0000_0000, 8, 3, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // Early rlast on beat 5, then a clean fill from the next entry
        push_fifo(32'hFFFF_FFD0);
        push_fifo(32'h8000_7FF8);
        send_burst(32'hFFFF_FFD0, 64'h5555_0000_0000_0000, 5, -1, 1'b0, 1'b0, 1'b1);
        wait_drain();
        send_burst(32'h8000_7FF8, 64'h7777_0000_0000_0000, 8, -1, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // Reset after four beats, then refill from the same head entry
        push_fifo(32'h4321_0018);
        send_burst(32'h4321_0018, 64'h9999_0000_0000_0000, 4, -1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rready", {511'd0, mem_rready_o}, '0);
        check("midrst_busy", {511'd0, fill_busy_o}, '0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_wren", {511'd0, wren_o}, '0);
            check("midrst_rden", {511'd0, fifo_rden_o}, '0);
        end
        rst_n = 1'b1;
        check("midrst_no_pop", 512'(wp - rp), 512'd1);
        send_burst(32'h4321_0018, 64'hBBBB_0000_0000_0000, 8, -1, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // Back-to-back fills, rvalid held high across WRITE/IDLE with random stalls
        push_fifo(32'h0F0F_0F08);
        push_fifo(32'h7654_3230);
        send_burst(32'h0F0F_0F08, 64'hC100_0000_0000_0000, 8, -1, 1'b1, 1'b1, 1'b1);
        send_burst(32'h7654_3230, 64'hC200_0000_0000_0000, 8, -1, 1'b1, 1'b0, 1'b1);
        check("fill_gap", 512'(first_hs_cyc), 512'(last_wren_cyc + 2));
        wait_drain();

        repeat (3) @(posedge clk);
        check("pop_count", 512'(rp), 512'(pushes));
        check("fifo_drained", {511'd0, fifo_empty}, 512'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
